pipe_trace_capture: RTL and testbench
=====================================

PIPE_TRACE_CAPTURE -- requirements
Module: pipe_trace_capture

Interface
REQ-001 Parameter STAGES, default 4: number of pipeline stages traced.
REQ-002 Parameter DATA_W, default 16: snapshot width per stage.
REQ-003 Parameter DEPTH, default 16: trace entries; power of 2, at least 4.
REQ-004 Parameter POST_TRIG, default 8: entries captured after the trigger entry; range 0..DEPTH-1.
REQ-005 Parameter CYC_W, default 16: cycle-stamp width.
REQ-006 clock  in  1  rising-edge clock.
REQ-007 reset  in  1  reset, synchronous, active-low.
REQ-008 stage_data  in  STAGES*DATA_W  packed stage snapshots; stage 0 in the LSBs.
REQ-009 stage_valid  in  STAGES  per-stage valid bits.
REQ-010 arm  in  1  start a capture (pulse).
REQ-011 trigger  in  1  capture trigger event.
REQ-012 rd_ready  in  1  readout consumer ready.
REQ-013 rd_valid  out  1  rd_data holds a valid entry.
REQ-014 rd_data  out  CYC_W+STAGES*DATA_W  entry in the form {cycle stamp, stage_data}.
REQ-015 rd_last  out  1  the current entry is the final one.
REQ-016 state  out  3  FSM state code: IDLE=0, ARMED=1, POST=2, LOAD=3, READ=4.
REQ-017 fill  out  clog2(DEPTH)+1  number of valid entries stored.

Function
REQ-018 A free-running cycle counter SHALL increment every clock, wrap modulo 2^CYC_W, and be 0 in the first cycle after reset.
REQ-019 Write qualifier: a write SHALL occur only when |stage_valid is 1 and state is ARMED or POST.
REQ-020 Each write SHALL store {cycle counter, stage_data} at wr_ptr, then advance wr_ptr modulo DEPTH.
REQ-021 fill SHALL increment on each write and saturate at DEPTH; once saturated, each new write overwrites the oldest entry.
REQ-022 IDLE -> ARMED on arm=1; wr_ptr and fill SHALL clear on this transition.
REQ-023 ARMED -> POST on trigger=1.
REQ-024 The trigger cycle SHALL write if qualified, and a post counter SHALL load POST_TRIG.
REQ-025 If POST_TRIG=0, the transition on trigger SHALL go ARMED -> LOAD instead.
REQ-026 In POST, each write SHALL decrement the post counter; the write that reaches 0 SHALL move POST -> LOAD.
REQ-027 Unqualified cycles SHALL NOT decrement the post counter.
REQ-028 If trigger occurs with fill=0 and stage_valid=0, the trigger cycle SHALL write nothing.
REQ-029 LOAD SHALL last one cycle: rd_ptr = wr_ptr if fill==DEPTH, else 0; the oldest entry is fetched into rd_data; the state then moves to READ.
REQ-030 If fill=0 at LOAD, the block SHALL return to IDLE with no rd_valid pulse.
REQ-031 READ: rd_valid=1; on rd_valid&rd_ready, rd_ptr SHALL advance and the next entry SHALL appear on the following cycle.
REQ-032 READ: rd_last=1 on the fill-th entry; its handshake SHALL move the state to IDLE.
REQ-033 While rd_valid=1 and rd_ready=0, rd_data and rd_last SHALL hold stable.
REQ-034 arm SHALL be ignored outside IDLE.
REQ-035 trigger SHALL be ignored outside ARMED; a trigger in POST SHALL NOT reload the post counter.
REQ-036 arm and trigger asserted in the same IDLE cycle: arm SHALL take effect and trigger SHALL be ignored.
REQ-037 fill SHALL remain readable and unchanged during LOAD and READ; it SHALL clear on the next arm.

Reset
REQ-038 With reset=0 at a clock edge: state=IDLE, fill=0, wr_ptr=rd_ptr=0, post counter=0, cycle counter=0, rd_valid=0, rd_last=0, rd_data=0.
REQ-039 Reset SHALL take priority over all inputs in any state, including mid-POST or mid-READ; the memory contents need not be cleared.

Verification (STAGES=2, DATA_W=8, DEPTH=8, POST_TRIG=3, CYC_W=8)
REQ-040 Reset: hold reset=0 for 2 cycles -> state=0, fill=0, rd_valid=0, rd_data=0.
REQ-041 Basic capture: arm; 2 valid samples; trigger with a valid sample; 3 valid samples -> fill=6; 6 entries read in write order; cycle stamps strictly increasing; rd_last on the 6th entry; state=0 afterwards.
REQ-042 Wrap: arm; 20 valid samples; trigger (sample 21); samples 22-24 -> fill=8; readout returns samples 17..24 in order.
REQ-043 Gaps: in POST, insert 5 cycles with stage_valid=0 -> no writes and post counter unchanged; capture ends only after 3 qualified writes.
REQ-044 Backpressure: in READ, hold rd_ready=0 for 4 cycles -> rd_data and rd_last stable and rd_ptr unchanged.
REQ-045 Reset mid-operation: reset=0 during POST with fill=5 -> next cycle state=0, fill=0, rd_valid=0; a subsequent arm restarts capture cleanly.

Source files
------------

// File: rtl/pipe_trace_capture.sv
// rtl/pipe_trace_capture.sv - armed/triggered pipeline-stage trace buffer with post-trigger window and stream readout
module pipe_trace_capture #(
    parameter int STAGES    = 4,
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8,
    parameter int CYC_W     = 16
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [STAGES*DATA_W-1:0]          stage_data,
    input  logic [STAGES-1:0]                 stage_valid,
    input  logic                              arm,
    input  logic                              trigger,
    input  logic                              rd_ready,
    output logic                              rd_valid,
    output logic [CYC_W+STAGES*DATA_W-1:0]    rd_data,
    output logic                              rd_last,
    output logic [2:0]                        state,
    output logic [$clog2(DEPTH):0]            fill
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int FILL_W  = PTR_W + 1;
    localparam int ENTRY_W = CYC_W + STAGES * DATA_W;

    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0]  POST_INIT = PTR_W'(POST_TRIG);
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);
    localparam logic [CYC_W-1:0]  CYC_ONE   = CYC_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_POST  = 3'd2,
        S_LOAD  = 3'd3,
        S_READ  = 3'd4
    } state_t;

    state_t             st;
    logic [CYC_W-1:0]   cyc_cnt;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   post_cnt;
    logic [FILL_W-1:0]  rd_cnt;
    logic [ENTRY_W-1:0] mem [DEPTH];

    logic               wr_en;
    logic [PTR_W-1:0]   start_ptr;
    logic [PTR_W-1:0]   rd_ptr_nxt;
    logic [FILL_W-1:0]  rd_cnt_nxt;

    assign state      = st;
    assign wr_en      = (|stage_valid) && ((st == S_ARMED) || (st == S_POST));
    // Once the ring has wrapped, the oldest entry sits where the next write would land.
    assign start_ptr  = (fill == FILL_FULL) ? wr_ptr : '0;
    assign rd_ptr_nxt = rd_ptr + PTR_ONE;
    assign rd_cnt_nxt = rd_cnt + FILL_ONE;

    always_ff @(posedge clock) begin
        if (reset && wr_en) begin
            mem[wr_ptr] <= {cyc_cnt, stage_data};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            st       <= S_IDLE;
            cyc_cnt  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            post_cnt <= '0;
            rd_cnt   <= '0;
            fill     <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            rd_data  <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + CYC_ONE;

            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                if (fill != FILL_FULL) begin
                    fill <= fill + FILL_ONE;
                end
            end

            case (st)
                S_IDLE: begin
                    if (arm) begin
                        st     <= S_ARMED;
                        wr_ptr <= '0;
                        fill   <= '0;
                    end
                end
                S_ARMED: begin
                    if (trigger) begin
                        if (POST_TRIG == 0) begin
                            st <= S_LOAD;
                        end else begin
                            post_cnt <= POST_INIT;
                            st       <= S_POST;
                        end
                    end
                end
                S_POST: begin
                    // Only qualified writes consume the post-trigger window.
                    if (wr_en) begin
                        post_cnt <= post_cnt - PTR_ONE;
                        if (post_cnt == PTR_ONE) begin
                            st <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (fill == '0) begin
                        st <= S_IDLE;
                    end else begin
                        rd_ptr   <= start_ptr;
                        rd_data  <= mem[start_ptr];
                        rd_cnt   <= '0;
                        rd_valid <= 1'b1;
                        rd_last  <= (fill == FILL_ONE);
                        st       <= S_READ;
                    end
                end
                S_READ: begin
                    if (rd_ready) begin
                        if (rd_last) begin
                            st       <= S_IDLE;
                            rd_valid <= 1'b0;
                            rd_last  <= 1'b0;
                            rd_data  <= '0;
                        end else begin
                            rd_ptr  <= rd_ptr_nxt;
                            rd_data <= mem[rd_ptr_nxt];
                            rd_cnt  <= rd_cnt_nxt;
                            rd_last <= (rd_cnt_nxt == (fill - FILL_ONE));
                        end
                    end
                end
                default: begin
                    st <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_trace_capture.sv
// tb/tb_pipe_trace_capture.sv - randomized and directed checks of pipe_trace_capture against a queue-based model
module tb_pipe_trace_capture;

    localparam int STAGES    = 2;
    localparam int DATA_W    = 8;
    localparam int DEPTH     = 8;
    localparam int POST_TRIG = 3;
    localparam int CYC_W     = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] stage_data;
    logic [1:0]  stage_valid;
    logic        arm;
    logic        trigger;
    logic        rd_ready;
    logic        rd_valid;
    logic [23:0] rd_data;
    logic        rd_last;
    logic [2:0]  state;
    logic [3:0]  fill;

    int checks = 0;
    int passes = 0;

    pipe_trace_capture #(
        .STAGES(STAGES), .DATA_W(DATA_W), .DEPTH(DEPTH),
        .POST_TRIG(POST_TRIG), .CYC_W(CYC_W)
    ) dut (
        .clock(clock), .reset(reset), .stage_data(stage_data),
        .stage_valid(stage_valid), .arm(arm), .trigger(trigger),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_last(rd_last), .state(state), .fill(fill)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        else passes++;
    endtask

    // Reference model: captured entries kept as a plain list holding the newest DEPTH samples.
    int          m_state = 0;
    int          m_post  = 0;
    int          m_rd    = 0;
    int          m_cyc   = 0;
    logic [23:0] m_q [$];

    always @(posedge clock) begin : model
        logic w;
        if (!reset) begin
            m_state = 0; m_post = 0; m_rd = 0; m_cyc = 0;
            m_q.delete();
        end else begin
            w = (|stage_valid) && (m_state == 1 || m_state == 2);
            if (w) begin
                m_q.push_back({m_cyc[7:0], stage_data});
                if (m_q.size() > DEPTH) void'(m_q.pop_front());
            end
            case (m_state)
                0: if (arm) begin m_q.delete(); m_state = 1; end
                1: if (trigger) begin
                       if (POST_TRIG == 0) m_state = 3;
                       else begin m_post = POST_TRIG; m_state = 2; end
                   end
                2: if (w) begin
                       m_post = m_post - 1;
                       if (m_post == 0) m_state = 3;
                   end
                3: if (m_q.size() == 0) m_state = 0;
                   else begin m_rd = 0; m_state = 4; end
                4: if (rd_ready) begin
                       if (m_rd == m_q.size() - 1) m_state = 0;
                       else m_rd = m_rd + 1;
                   end
                default: m_state = 0;
            endcase
            m_cyc = (m_cyc + 1) % 256;
        end
    end

    always @(negedge clock) begin : compare
        chk("state", state, m_state);
        chk("fill", fill, m_q.size());
        chk("rd_valid", rd_valid, m_state == 4);
        if (m_state == 4) begin
            chk("rd_data", rd_data, m_q[m_rd]);
            chk("rd_last", rd_last, m_rd == m_q.size() - 1);
        end else begin
            chk("rd_last_idle", rd_last, 0);
        end
    end

    task automatic drive(input logic a, input logic t, input logic [1:0] v,
                         input logic [15:0] d, input logic r);
        arm = a; trigger = t; stage_valid = v; stage_data = d; rd_ready = r;
        @(negedge clock);
    endtask

    task automatic sample(input int k);
        drive(1'b0, 1'b0, 2'b01, 16'(k), 1'b0);
    endtask

    logic [23:0] rd_log [$];

    task automatic drain(input bit rand_ready);
        bit done = 0;
        rd_log.delete();
        arm = 0; trigger = 0; stage_valid = 0;
        for (int i = 0; i < 300; i++) begin
            if (state == 3'd0) begin done = 1; break; end
            rd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rd_valid && rd_ready) rd_log.push_back(rd_data);
            @(negedge clock);
        end
        chk("drain_done", done, 1);
        rd_ready = 0;
    endtask

    task automatic check_log(input int first, input int n);
        logic [7:0] diff;
        chk("log_count", rd_log.size(), n);
        for (int i = 0; i < rd_log.size(); i++) begin
            chk("log_sample", rd_log[i][15:0], first + i);
            if (i > 0) begin
                diff = rd_log[i][23:16] - rd_log[i-1][23:16];
                chk("log_stamp_incr", (diff != 0) && (diff < 8'd128), 1);
            end
        end
    endtask

    logic [23:0] hold_data;
    logic        hold_last;

    initial begin
        reset = 0; arm = 0; trigger = 0; stage_valid = 0; stage_data = 0; rd_ready = 0;
        repeat (2) @(negedge clock);
        chk("rst_state", state, 0);
        chk("rst_fill", fill, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        reset = 1;
        drive(0, 0, 0, 0, 0);

        // basic capture
        drive(1, 0, 0, 0, 0);
        sample(1); sample(2);
        drive(0, 1, 2'b01, 16'd3, 0);
        sample(4); sample(5); sample(6);
        chk("basic_fill", fill, 6);
        chk("basic_load", state, 3);
        drain(0);
        check_log(1, 6);
        chk("basic_end_state", state, 0);

        // wrap
        drive(1, 0, 0, 0, 0);
        for (int k = 1; k <= 20; k++) sample(k);
        drive(0, 1, 2'b11, 16'd21, 0);
        sample(22); sample(23); sample(24);
        chk("wrap_fill", fill, 8);
        drain(1);
        check_log(17, 8);

        // gaps in POST, including a trigger that must not reload the window
        drive(1, 0, 0, 0, 0);
        sample(1);
        drive(0, 1, 2'b10, 16'd2, 0);
        sample(3);
        for (int g = 0; g < 5; g++) begin
            drive(0, g == 2, 2'b00, 16'hffff, 0);
            chk("gap_state", state, 2);
            chk("gap_fill", fill, 3);
        end
        sample(4);
        chk("gap_still_post", state, 2);
        sample(5);
        chk("gap_done_state", state, 3);
        chk("gap_done_fill", fill, 5);
        drain(0);
        check_log(1, 5);

        // backpressure
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 2'b01, 16'd1, 0);
        sample(2); sample(3); sample(4);
        drive(0, 0, 0, 0, 0);
        chk("bp_read", state, 4);
        hold_data = rd_data;
        hold_last = rd_last;
        chk("bp_first", hold_data[15:0], 1);
        for (int b = 0; b < 4; b++) begin
            drive(0, 0, 0, 0, 0);
            chk("bp_data_stable", rd_data, hold_data);
            chk("bp_last_stable", rd_last, hold_last);
        end
        drain(0);
        check_log(1, 4);

        // reset mid-POST
        drive(1, 0, 0, 0, 0);
        sample(1); sample(2);
        drive(0, 1, 2'b01, 16'd3, 0);
        sample(4); sample(5);
        chk("mid_state", state, 2);
        chk("mid_fill", fill, 5);
        reset = 0;
        drive(0, 0, 2'b01, 16'd9, 1);
        reset = 1;
        chk("mid_rst_state", state, 0);
        chk("mid_rst_fill", fill, 0);
        chk("mid_rst_valid", rd_valid, 0);
        drive(1, 1, 0, 0, 0);
        drive(0, 1, 2'b01, 16'd7, 0);
        sample(8); sample(9); sample(10);
        drain(0);
        check_log(7, 4);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom_range(0, 299) != 0);
            drive(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 9) == 0),
                  2'($urandom), 16'($urandom), 1'($urandom_range(0, 3) != 0));
        end
        reset = 1;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
